// File: rtl/wr_ptr_full_level_if.sv
// Write-side bus of the async FIFO: the write client request, the synchronised
// read pointer and programming inputs, and the status/pointer outputs.
//
// Handshake: winc is a request, full is the (inverted) ready. A write is taken
// on a wclk edge only if full was low before that edge. A winc while full is
// dropped, leaves the pointers alone and sets the sticky overflow flag.
interface wr_ptr_full_level_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 winc;
  logic [ADDR_SIZE:0]   wq_rptr;
  logic [ADDR_SIZE:0]   afull_thresh;
  logic                 ovf_clr;
  logic                 full;
  logic                 almost_full;
  logic                 overflow;
  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wlevel;
  logic [ADDR_SIZE:0]   wfree;

  // Write client / environment side
  modport master (
    output winc, wq_rptr, afull_thresh, ovf_clr,
    input  full, almost_full, overflow, wr_ptr, waddr, wlevel, wfree
  );

  // Pointer/status block side
  modport slave (
    input  winc, wq_rptr, afull_thresh, ovf_clr,
    output full, almost_full, overflow, wr_ptr, waddr, wlevel, wfree
  );
endinterface

// File: rtl/wr_ptr_full_level.sv
// Write pointer, full, fill level, almost-full and overflow tracking for the
// write clock domain of an asynchronous FIFO. All outputs are registered;
// nothing combinational runs from winc to an output.
module wr_ptr_full_level #(
  parameter int ADDR_SIZE = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  wr_ptr_full_level_if.slave    bus
);
  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] DEPTH_V   = {1'b1, {ADDR_SIZE{1'b0}}};
  // Full when the Gray write pointer equals the read pointer with its two
  // top bits inverted; this mask flips exactly those two bits.
  localparam logic [PW-1:0] FULL_MASK = DEPTH_V | (DEPTH_V >> 1);

  logic [PW-1:0] wr_ptr_bin;
  logic [PW-1:0] gray_r;
  logic [PW-1:0] wlevel_r;
  logic [PW-1:0] wfree_r;
  logic          full_r;
  logic          afull_r;
  logic          ovf_r;

  logic          accept;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] thresh_sat;
  logic          full_next;
  logic          afull_next;
  logic          ovf_next;

  // Accept against the registered full and advance the binary/Gray pointer
  always_comb begin
    accept    = bus.winc & ~full_r;
    bin_next  = wr_ptr_bin + {{ADDR_SIZE{1'b0}}, accept};
    gray_next = bin_next ^ (bin_next >> 1);
  end

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of
  // all Gray bits from i up to the MSB
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(bus.wq_rptr >> i);
    end
  end

  // Next-state flags and counts, all based on the post-edge pointer
  always_comb begin
    full_next  = (gray_next == (bus.wq_rptr ^ FULL_MASK));
    level_next = bin_next - rbin;
    thresh_sat = (bus.afull_thresh > DEPTH_V) ? DEPTH_V : bus.afull_thresh;
    afull_next = (bus.afull_thresh != '0) && (level_next >= thresh_sat);
    // A blocked write sets the flag and beats a simultaneous clear
    ovf_next   = (bus.winc & full_r) | (ovf_r & ~bus.ovf_clr);
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wr_ptr_bin <= '0;
      gray_r     <= '0;
      full_r     <= 1'b0;
      afull_r    <= 1'b0;
      ovf_r      <= 1'b0;
      wlevel_r   <= '0;
      wfree_r    <= DEPTH_V;
    end else begin
      wr_ptr_bin <= bin_next;
      gray_r     <= gray_next;
      full_r     <= full_next;
      afull_r    <= afull_next;
      ovf_r      <= ovf_next;
      wlevel_r   <= level_next;
      wfree_r    <= DEPTH_V - level_next;
    end
  end

  assign bus.full        = full_r;
  assign bus.almost_full = afull_r;
  assign bus.overflow    = ovf_r;
  assign bus.wr_ptr      = gray_r;
  assign bus.waddr       = wr_ptr_bin[ADDR_SIZE-1:0];
  assign bus.wlevel      = wlevel_r;
  assign bus.wfree       = wfree_r;
endmodule

// File: tb/tb_wr_ptr_full_level.sv
// Bench for wr_ptr_full_level: a depth-16 instance (a) and a depth-2
// instance (b) share clock and reset. A word-count model (writes accepted,
// reads seen) predicts every output after each edge.
module tb_wr_ptr_full_level;
  logic wclk;
  logic wrst;

  wr_ptr_full_level_if #(.ADDR_SIZE(4)) bus_a ();
  wr_ptr_full_level_if #(.ADDR_SIZE(1)) bus_b ();

  wr_ptr_full_level #(.ADDR_SIZE(4)) dut_a (.wclk(wclk), .wrst(wrst), .bus(bus_a));
  wr_ptr_full_level #(.ADDR_SIZE(1)) dut_b (.wclk(wclk), .wrst(wrst), .bus(bus_b));

  // ---------------- clock / reset ----------------
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // model state per instance: 0 = a (depth 16), 1 = b (depth 2)
  int m_w[2];
  int m_r[2];
  bit m_ovf[2];

  string fld_name[7] = '{"full", "almost_full", "overflow", "wr_ptr", "waddr", "wlevel", "wfree"};

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic read_outs(input int inst, output int act[7]);
    if (inst == 0) begin
      act[0] = int'(bus_a.full);   act[1] = int'(bus_a.almost_full);
      act[2] = int'(bus_a.overflow); act[3] = int'(bus_a.wr_ptr);
      act[4] = int'(bus_a.waddr);  act[5] = int'(bus_a.wlevel);
      act[6] = int'(bus_a.wfree);
    end else begin
      act[0] = int'(bus_b.full);   act[1] = int'(bus_b.almost_full);
      act[2] = int'(bus_b.overflow); act[3] = int'(bus_b.wr_ptr);
      act[4] = int'(bus_b.waddr);  act[5] = int'(bus_b.wlevel);
      act[6] = int'(bus_b.wfree);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_w[k] = 0; m_r[k] = 0; m_ovf[k] = 1'b0;
    end
  endtask

  // ---------------- driver: one clock cycle with model + check ----------------
  // Called at posedge+1; rnew is the total number of words the reader has taken.
  task automatic cycle(input int inst, input bit w, input bit c, input int rnew);
    int aw, depth, pmod, th, lvl, prev_ptr;
    int act[7];
    bit acc;
    aw    = (inst == 0) ? 4 : 1;
    depth = 1 << aw;
    pmod  = 2 * depth;
    if (inst == 0) begin
      bus_a.winc = w; bus_a.ovf_clr = c;
      bus_a.wq_rptr = 5'(gray(rnew % pmod));
      th = int'(bus_a.afull_thresh);
      prev_ptr = int'(bus_a.wr_ptr);
    end else begin
      bus_b.winc = w; bus_b.ovf_clr = c;
      bus_b.wq_rptr = 2'(gray(rnew % pmod));
      th = int'(bus_b.afull_thresh);
      prev_ptr = int'(bus_b.wr_ptr);
    end
    acc = w && ((m_w[inst] - m_r[inst]) != depth);
    @(posedge wclk);
    m_ovf[inst] = (w && !acc) ? 1'b1 : (c ? 1'b0 : m_ovf[inst]);
    m_w[inst] += int'(acc);
    m_r[inst] = rnew;
    lvl = m_w[inst] - m_r[inst];
    exp_q.push_back(32'(lvl == depth));
    exp_q.push_back(32'((th != 0) && (lvl >= ((th > depth) ? depth : th))));
    exp_q.push_back(32'(m_ovf[inst]));
    exp_q.push_back(32'(gray(m_w[inst] % pmod)));
    exp_q.push_back(32'(m_w[inst] % depth));
    exp_q.push_back(32'(lvl));
    exp_q.push_back(32'(depth - lvl));
    #1;
    read_outs(inst, act);
    for (int k = 0; k < 7; k++) begin
      check(fld_name[k], act[k], int'(exp_q.pop_front()));
    end
    if (acc) check("gray_one_bit_step", $countones(prev_ptr ^ act[3]), 1);
  endtask

  // Random traffic on one instance; reads only ever take words already written
  task automatic rand_phase(input int inst, input int n, input int th, input int wprob, input int rprob);
    bit w, c, rd;
    if (inst == 0) bus_a.afull_thresh = 5'(th);
    else           bus_b.afull_thresh = 2'(th);
    for (int k = 0; k < n; k++) begin
      w  = ($urandom_range(0, 99) < wprob);
      c  = ($urandom_range(0, 7) == 0);
      rd = (m_r[inst] < m_w[inst]) && ($urandom_range(0, 99) < rprob);
      cycle(inst, w, c, m_r[inst] + int'(rd));
    end
  endtask

  // Reset asserted mid-cycle: outputs clear at once, winc during reset is ignored
  task automatic reset_mid();
    int act[7];
    #4;
    wrst = 1'b1;
    #1;
    read_outs(0, act);
    check("rst_full", act[0], 0);     check("rst_afull", act[1], 0);
    check("rst_ovf", act[2], 0);      check("rst_wr_ptr", act[3], 0);
    check("rst_waddr", act[4], 0);    check("rst_wlevel", act[5], 0);
    check("rst_wfree", act[6], 16);
    check("rst_b_wfree", int'(bus_b.wfree), 2);
    bus_a.winc = 1'b1; bus_a.ovf_clr = 1'b0; bus_a.wq_rptr = '0;
    bus_b.winc = 1'b0; bus_b.ovf_clr = 1'b0; bus_b.wq_rptr = '0;
    @(posedge wclk); #1;
    check("rst_no_write_ptr", int'(bus_a.wr_ptr), 0);
    check("rst_no_write_lvl", int'(bus_a.wlevel), 0);
    bus_a.winc = 1'b0;
    #3;
    wrst = 1'b0;
    model_reset();
    @(posedge wclk); #1;
    read_outs(0, act);
    check("hold_wr_ptr", act[3], 0);  check("hold_wlevel", act[5], 0);
    check("hold_wfree", act[6], 16);  check("hold_full", act[0], 0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit winc;
    bit clr;
    int rbin;
    bit e_full;
    bit e_af;
    bit e_ovf;
    int e_lvl;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int act[7];
    int guard;
    bit w, rd;
    int lvl;

    // fill (12 = almost-full threshold), overflow, set-wins, clear, drain
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b0, 0, (i == 15), (i >= 11), 1'b0, i + 1};
    tbl[16] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 16};
    tbl[17] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1, 16};
    tbl[18] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 16};
    tbl[19] = '{1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 12};
    tbl[20] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 11};

    wrst = 1'b1;
    bus_a.winc = 1'b0; bus_a.ovf_clr = 1'b0; bus_a.wq_rptr = '0; bus_a.afull_thresh = 5'd12;
    bus_b.winc = 1'b0; bus_b.ovf_clr = 1'b0; bus_b.wq_rptr = '0; bus_b.afull_thresh = 2'd1;
    model_reset();
    #2;
    read_outs(0, act);
    check("init_full", act[0], 0);   check("init_wlevel", act[5], 0);
    check("init_wfree", act[6], 16); check("init_wr_ptr", act[3], 0);
    #10;
    wrst = 1'b0;
    @(posedge wclk); #1;

    for (int i = 0; i < 21; i++) begin
      cycle(0, tbl[i].winc, tbl[i].clr, tbl[i].rbin);
      check("tbl_full", int'(bus_a.full), int'(tbl[i].e_full));
      check("tbl_afull", int'(bus_a.almost_full), int'(tbl[i].e_af));
      check("tbl_ovf", int'(bus_a.overflow), int'(tbl[i].e_ovf));
      check("tbl_wlevel", int'(bus_a.wlevel), tbl[i].e_lvl);
      check("tbl_wfree", int'(bus_a.wfree), 16 - tbl[i].e_lvl);
      if (i == 15) begin
        check("full_wr_ptr", int'(bus_a.wr_ptr), 24);
        check("full_waddr", int'(bus_a.waddr), 0);
      end
    end

    // reset in the middle of operation, then the wrap stream
    reset_mid();
    bus_a.afull_thresh = 5'd12;
    guard = 0;
    while (m_w[0] < 70 && guard < 400) begin
      lvl = m_w[0] - m_r[0];
      w   = ($urandom_range(0, 3) != 0);
      if (lvl >= 9)      rd = 1'b1;
      else if (lvl <= 3) rd = 1'b0;
      else               rd = $urandom_range(0, 1) == 1;
      cycle(0, w, 1'b0, m_r[0] + int'(rd));
      guard++;
    end
    check("wrap_writes_done", m_w[0], 70);

    // threshold corners and general random traffic
    rand_phase(0, 120, 0, 80, 30);
    rand_phase(0, 120, 20, 80, 30);
    for (int p = 0; p < 4; p++) rand_phase(0, 40, $urandom_range(0, 31), 60, 50);
    reset_mid();
    rand_phase(0, 30, 16, 90, 10);

    // depth-2 instance: fill, overflow, drain, clear
    bus_a.winc = 1'b0;
    bus_b.afull_thresh = 2'd1;
    cycle(1, 1'b1, 1'b0, 0);
    check("b_lvl1_afull", int'(bus_b.almost_full), 1);
    check("b_lvl1_full", int'(bus_b.full), 0);
    cycle(1, 1'b1, 1'b0, 0);
    check("b_full", int'(bus_b.full), 1);
    check("b_full_wr_ptr", int'(bus_b.wr_ptr), 3);
    check("b_full_waddr", int'(bus_b.waddr), 0);
    cycle(1, 1'b1, 1'b0, 0);
    check("b_overflow", int'(bus_b.overflow), 1);
    cycle(1, 1'b0, 1'b0, 1);
    check("b_drain_full", int'(bus_b.full), 0);
    check("b_drain_lvl", int'(bus_b.wlevel), 1);
    cycle(1, 1'b0, 1'b1, 1);
    check("b_ovf_clr", int'(bus_b.overflow), 0);
    rand_phase(1, 60, 2, 70, 50);
    rand_phase(1, 60, 3, 70, 50);
    rand_phase(1, 60, 0, 70, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wr_ptr_full_level.md
Name: wr_ptr_full_level

Overview:
Write-side pointer and status block for the asynchronous FIFO, parametrised in depth. It keeps the binary and Gray write pointers, generates the RAM write address and registered full, and computes a registered fill level and free count from the synchronised Gray read pointer. It adds a programmable almost-full flag and a sticky overflow error flag with clear. It sits in the wclk domain between the write client, the dual-port RAM and the read-to-write pointer synchroniser.

Parameters:
ADDR_SIZE, 4, address width; DEPTH = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits; legal range 1..16.

Ports:
wclk  input  1  write clock.
wrst  input  1  reset; asynchronous, active-high.
winc  input  1  write request.
wq_rptr  input  ADDR_SIZE+1  read pointer, Gray code, already synchronised to wclk.
afull_thresh  input  ADDR_SIZE+1  almost-full threshold in words; quasi-static.
ovf_clr  input  1  clears overflow; one-cycle pulse.
full  output  1  FIFO full; registered.
almost_full  output  1  level at or above threshold; registered.
overflow  output  1  sticky: write attempted while full.
wr_ptr  output  ADDR_SIZE+1  Gray write pointer to the synchroniser; registered.
waddr  output  ADDR_SIZE  RAM write address = wr_ptr_bin[ADDR_SIZE-1:0].
wlevel  output  ADDR_SIZE+1  words stored, 0..DEPTH; registered.
wfree  output  ADDR_SIZE+1  DEPTH - wlevel; registered.

Behaviour:
- Reset (async, wrst=1): wr_ptr_bin=0, wr_ptr=0, full=0, almost_full=0, overflow=0, wlevel=0, wfree=DEPTH. waddr=0 follows.
- Reset mid-operation: all state returns to reset values immediately. No write is accepted while wrst=1.
- Write accept condition: accept = winc & ~full, using the registered full.
- Pointer arithmetic:
  - bin_next = wr_ptr_bin + accept, modulo 2**(ADDR_SIZE+1). The pointer wraps from 2**(ADDR_SIZE+1)-1 to 0 silently.
  - gray_next = bin_next ^ (bin_next >> 1).
  - On each wclk edge, wr_ptr_bin <= bin_next and wr_ptr <= gray_next.
- Full:
  - full_next = (gray_next == {~wq_rptr[top two bits], wq_rptr[remaining bits]}). For ADDR_SIZE=1 there are no remaining bits.
  - Registered, so full asserts on the same edge that accepts the DEPTH-th outstanding write.
  - full deasserts on the first edge at which the sampled wq_rptr shows a read.
- Level:
  - rbin = Gray-to-binary of wq_rptr (prefix XOR from the MSB down).
  - level_next = (bin_next - rbin) mod 2**(ADDR_SIZE+1).
  - wlevel <= level_next; wfree <= DEPTH - level_next.
  - Invariants: wlevel+wfree == DEPTH; full == (wlevel == DEPTH).
- Almost full:
  - almost_full <= (afull_thresh != 0) && (level_next >= min(afull_thresh, DEPTH)).
  - A threshold of 0 disables the flag. Thresholds above DEPTH saturate to DEPTH, which makes almost_full equal to full.
- Overflow:
  - Set on any edge where winc & full.
  - Cleared on an edge with ovf_clr=1.
  - If set and clear happen together, set wins.
  - An overflowing write never changes the pointers.
- Latency: all flags and counts reflect state after the edge, using wq_rptr sampled at that edge. There is no combinational path from winc to any output.
- Simultaneous write and read-pointer advance: both are applied in the same level_next. The level stays unchanged if exactly one word is written and one is read.
- No simulation $display in synthesizable RTL.

Test Plan:
1. Reset: ADDR_SIZE=4, assert wrst mid-clock -> outputs immediately 0 except wfree=16; after release with winc=0, values hold.
2. Fill: wq_rptr=0, afull_thresh=12, winc=1 for 17 cycles.
   - almost_full rises on the edge of the 12th accept (wlevel=12).
   - full rises on the 16th accept; at that point wr_ptr=5'b11000, waddr=0, wlevel=16, wfree=0.
   - The 17th request is blocked and overflow=1.
3. Overflow clear: hold winc=1 while full and pulse ovf_clr -> overflow stays 1 (set wins). With winc=0 and ovf_clr=1 -> overflow=0 on the next edge.
4. Drain visibility: from full, drive wq_rptr=5'b00110 (bin 4) -> next edge full=0, wlevel=12, wfree=4, almost_full=1. Then drive wq_rptr=5'b00111 (bin 5) -> wlevel=11, almost_full=0.
5. Wrap: stream 70 writes with a read model that keeps the level between 3 and 10.
   - wr_ptr_bin wraps 31->0 twice.
   - The Gray pointer changes exactly 1 bit per accept.
   - wlevel matches the scoreboard every cycle; full is never set.
6. Threshold corners: afull_thresh=0 -> almost_full never asserts. afull_thresh=20 -> almost_full tracks full exactly. Repeat scenarios 2 and 4 with ADDR_SIZE=1 (full at level 2).
